// File: rtl/color_frame_ctrl_pkg.sv
// Shared colour codes, controller states and colour helpers for the
// frame-synchronous colour controller.
package color_frame_ctrl_pkg;

   localparam logic [1:0] COLOR_BLACK = 2'd0;
   localparam logic [1:0] COLOR_1     = 2'd1;
   localparam logic [1:0] COLOR_2     = 2'd2;
   localparam logic [1:0] COLOR_3     = 2'd3;

   typedef enum logic [1:0] {
      ST_MANUAL_IDLE = 2'd0,
      ST_MANUAL_PEND = 2'd1,
      ST_AUTO        = 2'd2
   } state_e;

   // Auto-cycle order 1 -> 2 -> 3 -> 0 -> 1 is a plain modulo-4 increment.
   function automatic logic [1:0] next_color(input logic [1:0] color);
      return color + 2'd1;
   endfunction

   function automatic logic [3:0] color_to_led(input logic [1:0] color);
      logic [3:0] led;
      case (color)
         COLOR_1:     led = 4'b0001;
         COLOR_2:     led = 4'b0010;
         COLOR_3:     led = 4'b0100;
         COLOR_BLACK: led = 4'b1000;
         default:     led = 4'b0001;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/color_frame_ctrl_switch_debounce.sv
// One switch channel: 2-FF synchroniser, stability counter, debounced state
// and a one-cycle pulse on each debounced press (releases are silent).
module color_frame_ctrl_switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          state_q, state_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Stability counter and debounced-state update
   always_comb begin
      state_d = state_q;
      press_d = 1'b0;
      cnt_d   = {CW{1'b0}};
      if (sync2_q != state_q) begin
         if (cnt_q == CNT_MAX) begin
            state_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = {CW{1'b0}};
      end
   end

   // Synchroniser and debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/color_frame_ctrl.sv
// Frame-synchronous colour controller: debounced switch presses become colour
// requests that commit only at vsync, plus an auto-cycle mode.
module color_frame_ctrl
   import color_frame_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int AUTO_FRAMES      = 60,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [3:0] i_switch,
   input  logic       i_vsync,
   output logic [1:0] o_color,
   output logic [3:0] o_led,
   output logic       o_pending,
   output logic       o_auto
);

   localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_MAX = FW'(AUTO_FRAMES - 1);
   localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [3:0]    press_s;
   logic          any_press_s;
   logic [1:0]    req_s;
   logic          vs_sync1_q, vs_sync2_q, vs_dly_q;
   logic          frame_start_s;
   state_e        state_q, state_d, state_m;
   logic [1:0]    color_q, color_d, color_m;
   logic [1:0]    pend_q, pend_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_m;
   logic [3:0]    led_q, led_d;
   logic          pending_q, pending_d;
   logic          auto_q, auto_d;

   for (genvar i = 0; i < 4; i++) begin : g_sw
      color_frame_ctrl_switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (i_clock),
         .rst_n  (i_reset_n),
         .i_raw  (i_switch[i]),
         .o_press(press_s[i])
      );
   end

   // Fixed-priority request: switch1 > switch2 > switch3 > switch4
   always_comb begin
      any_press_s = |press_s;
      if (press_s[0]) begin
         req_s = COLOR_1;
      end else if (press_s[1]) begin
         req_s = COLOR_2;
      end else if (press_s[2]) begin
         req_s = COLOR_3;
      end else begin
         req_s = COLOR_BLACK;
      end
   end

   assign frame_start_s = (VSYNC_ACTIVE_LOW != 0) ? (~vs_sync2_q & vs_dly_q)
                                                  : (vs_sync2_q & ~vs_dly_q);

   // Next state: frame-boundary commit first, then the press against the result
   always_comb begin
      state_m     = state_q;
      color_m     = color_q;
      frame_cnt_m = frame_cnt_q;
      pend_d      = pend_q;
      case (state_q)
         ST_MANUAL_PEND: begin
            if (frame_start_s) begin
               color_m = pend_q;
               state_m = ST_MANUAL_IDLE;
            end else begin
               state_m = ST_MANUAL_PEND;
            end
         end
         ST_AUTO: begin
            if (frame_start_s) begin
               if (frame_cnt_q == FRAME_MAX) begin
                  color_m     = next_color(color_q);
                  frame_cnt_m = {FW{1'b0}};
               end else begin
                  frame_cnt_m = frame_cnt_q + FW'(1);
               end
            end else begin
               frame_cnt_m = frame_cnt_q;
            end
         end
         default: state_m = state_q;
      endcase

      state_d     = state_m;
      color_d     = color_m;
      frame_cnt_d = frame_cnt_m;
      if (any_press_s) begin
         case (state_m)
            ST_MANUAL_IDLE: begin
               if (req_s == color_m) begin
                  state_d     = ST_AUTO;
                  frame_cnt_d = {FW{1'b0}};
               end else begin
                  state_d = ST_MANUAL_PEND;
                  pend_d  = req_s;
               end
            end
            ST_MANUAL_PEND: pend_d = req_s;
            ST_AUTO: begin
               if (req_s == color_m) begin
                  state_d = ST_MANUAL_IDLE;
               end else begin
                  state_d     = ST_MANUAL_PEND;
                  pend_d      = req_s;
                  frame_cnt_d = {FW{1'b0}};
               end
            end
            default: state_d = ST_MANUAL_IDLE;
         endcase
      end else begin
         state_d = state_m;
      end

      led_d     = color_to_led(color_d);
      pending_d = (state_d == ST_MANUAL_PEND);
      auto_d    = (state_d == ST_AUTO);
   end

   // Controller state, vsync edge detector and registered outputs
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vs_sync1_q  <= VS_IDLE;
         vs_sync2_q  <= VS_IDLE;
         vs_dly_q    <= VS_IDLE;
         state_q     <= ST_MANUAL_IDLE;
         color_q     <= COLOR_1;
         pend_q      <= COLOR_1;
         frame_cnt_q <= {FW{1'b0}};
         led_q       <= 4'b0001;
         pending_q   <= 1'b0;
         auto_q      <= 1'b0;
      end else begin
         vs_sync1_q  <= i_vsync;
         vs_sync2_q  <= vs_sync1_q;
         vs_dly_q    <= vs_sync2_q;
         state_q     <= state_d;
         color_q     <= color_d;
         pend_q      <= pend_d;
         frame_cnt_q <= frame_cnt_d;
         led_q       <= led_d;
         pending_q   <= pending_d;
         auto_q      <= auto_d;
      end
   end

   assign o_color   = color_q;
   assign o_led     = led_q;
   assign o_pending = pending_q;
   assign o_auto    = auto_q;

endmodule

// File: tb/tb_color_frame_ctrl.sv
// Directed bench for color_frame_ctrl with a queue of expected output states.
module tb_color_frame_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic       vsync;
   logic [1:0] color;
   logic [3:0] led;
   logic       pending;
   logic       auto_m;

   typedef struct {
      string      tag;
      logic [1:0] color;
      logic       pend;
      logic       aut;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   color_frame_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .AUTO_FRAMES     (2),
      .VSYNC_ACTIVE_LOW(1)
   ) dut (
      .i_clock  (clk),
      .i_reset_n(rst_n),
      .i_switch (sw),
      .i_vsync  (vsync),
      .o_color  (color),
      .o_led    (led),
      .o_pending(pending),
      .o_auto   (auto_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] led_for(input logic [1:0] c);
      logic [3:0] l;
      if (c == 2'd0) l = 4'b1000;
      else           l = 4'b0001 << (c - 2'd1);
      return l;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [1:0] c, input logic p, input logic a);
      exp_t e;
      e.tag = tag; e.color = c; e.pend = p; e.aut = a;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      n_checks++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected>0");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         assert (color === e.color) else begin
            n_fail++;
            $error("FAIL %s.color observed=%0d expected=%0d", e.tag, color, e.color);
         end
         n_checks++;
         assert (led === led_for(e.color)) else begin
            n_fail++;
            $error("FAIL %s.led observed=%b expected=%b", e.tag, led, led_for(e.color));
         end
         n_checks++;
         assert (pending === e.pend) else begin
            n_fail++;
            $error("FAIL %s.pending observed=%b expected=%b", e.tag, pending, e.pend);
         end
         n_checks++;
         assert (auto_m === e.aut) else begin
            n_fail++;
            $error("FAIL %s.auto observed=%b expected=%b", e.tag, auto_m, e.aut);
         end
      end
   endtask

   // Hold a switch pattern long enough to debounce, then release it fully.
   task automatic press(input logic [3:0] mask, input string tag,
                        input logic [1:0] c, input logic p, input logic a);
      sw = mask;
      push(tag, c, p, a);
      tick(10);
      check();
      sw = 4'b0000;
      tick(8);
   endtask

   // One vsync pulse; the result must appear exactly on the third edge.
   task automatic frame(input string tag, input logic [1:0] c_before,
                        input logic p_before, input logic [1:0] c, input logic p,
                        input logic a);
      vsync = 1'b0;
      push({tag, "_pre"}, c_before, p_before, a);
      push(tag, c, p, a);
      tick(2);
      check();
      tick(1);
      check();
      vsync = 1'b1;
      tick(4);
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = 4'b0000;
      vsync = 1'b1;
      tick(2);
      push("reset", 2'd1, 1'b0, 1'b0);
      check();
      rst_n = 1'b1;
      tick(2);

      // 1: switch2 request waits for the frame boundary
      sw = 4'b0010;
      push("sw2_debouncing", 2'd1, 1'b0, 1'b0);
      push("sw2_pending", 2'd1, 1'b1, 1'b0);
      tick(6);
      check();
      tick(1);
      check();
      tick(3);
      sw = 4'b0000;
      tick(8);
      frame("commit2", 2'd1, 1'b1, 2'd2, 1'b0, 1'b0);

      // 2: short glitch ignored; simultaneous presses resolve to switch1
      sw = 4'b0100;
      tick(3);
      sw = 4'b0000;
      push("glitch", 2'd2, 1'b0, 1'b0);
      tick(10);
      check();
      press(4'b1001, "prio_1_over_4", 2'd2, 1'b1, 1'b0);
      frame("commit1", 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);

      // 3: same-colour press enters auto; step every second frame
      press(4'b0001, "enter_auto", 2'd1, 1'b0, 1'b1);
      frame("auto_f1", 2'd1, 1'b0, 2'd1, 1'b0, 1'b1);
      frame("auto_f2", 2'd1, 1'b0, 2'd2, 1'b0, 1'b1);
      frame("auto_f3", 2'd2, 1'b0, 2'd2, 1'b0, 1'b1);
      frame("auto_f4", 2'd2, 1'b0, 2'd3, 1'b0, 1'b1);
      frame("auto_f5", 2'd3, 1'b0, 2'd3, 1'b0, 1'b1);
      frame("auto_f6", 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);

      // 4: last request before the boundary wins
      press(4'b0100, "auto_to_pend3", 2'd0, 1'b1, 1'b0);
      press(4'b1000, "overwrite_0", 2'd0, 1'b1, 1'b0);
      frame("commit0_not3", 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);

      // 5: press and frame_start on the same edge
      press(4'b0010, "pend2", 2'd0, 1'b1, 1'b0);
      sw = 4'b0100;
      tick(4);
      vsync = 1'b0;
      push("coincide_pre", 2'd0, 1'b1, 1'b0);
      push("coincide", 2'd2, 1'b1, 1'b0);
      tick(2);
      check();
      tick(1);
      check();
      tick(3);
      sw    = 4'b0000;
      vsync = 1'b1;
      tick(8);
      frame("commit3_late", 2'd2, 1'b1, 2'd3, 1'b0, 1'b0);

      // 6: async reset in auto mode with a vsync edge in flight
      press(4'b0100, "auto_again", 2'd3, 1'b0, 1'b1);
      vsync = 1'b0;
      tick(1);
      rst_n = 1'b0;
      #1;
      push("async_reset", 2'd1, 1'b0, 1'b0);
      check();
      tick(2);
      rst_n = 1'b1;
      push("post_reset", 2'd1, 1'b0, 1'b0);
      tick(6);
      check();
      vsync = 1'b1;
      tick(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
